// File: rtl/lpm_fifo_dc_usedw_sync.sv
// lpm_fifo_dc_usedw_sync
//   Per-domain pointer and used-word count stage of the LPM dual-clock FIFO.
//   One instance sits in each clock domain. The instance:
//     - owns the local pointer (write side or read side);
//     - publishes that pointer to the other domain in Gray code;
//     - resynchronises the other side's Gray pointer;
//     - derives the used-word count for the flag stage of the same domain.
//
//   Parameters:
//     lpm_widthad  address width W; pointers are W+1 bits wide
//     lpm_mode     "WRITE": local pointer is the write pointer
//                  "READ" : local pointer is the read pointer
//                  any other value behaves as "READ"
//     delay_stages synchroniser depth on remote_gray, 0..4
//                  0 gives a direct pass-through
//                  values outside 0..4 fall back to 2
//
//   Optional build macro LPM_FIFO_DC_USEDW_REG_EN:
//     When defined, usedw/usedw_msb come from an output register that aclr
//     clears. This adds one clock of latency on both the local and the remote
//     path. local_gray and local_addr timing does not change.
//
//   Handshake: none. inc is a single-cycle qualified strobe. It is sampled on
//   every rising edge of clock and has no back-pressure.
module lpm_fifo_dc_usedw_sync #(
    parameter int    lpm_widthad  = 1,
    parameter string lpm_mode     = "READ",
    parameter int    delay_stages = 2
) (
    input  logic                   clock,
    input  logic                   aclr,
    input  logic                   inc,
    input  logic [lpm_widthad:0]   remote_gray,
    output logic [lpm_widthad:0]   local_gray,
    output logic [lpm_widthad-1:0] local_addr,
    output logic [lpm_widthad-1:0] usedw,
    output logic                   usedw_msb
);

    localparam int W = lpm_widthad;

    // Out-of-range synchroniser depths fall back to the common two-flop chain.
    localparam int SYNC_N = ((delay_stages < 0) || (delay_stages > 4)) ? 2 : delay_stages;

    // Anything that is not exactly "WRITE" is treated as the read side.
    localparam bit IS_WRITE = (lpm_mode == "WRITE");

    // A completely full FIFO: count == 2^W. Larger counts are illegal.
    localparam logic [W:0] FULL_CNT = {1'b1, {W{1'b0}}};

    // ------------------------------------------------------------------
    // Local pointer, binary and Gray.
    // ------------------------------------------------------------------
    logic [W:0] ptr_q;
    logic [W:0] ptr_d;
    logic [W:0] gray_q;
    logic [W:0] gray_d;

    // Next local pointer.
    // The published Gray value is encoded from the next binary value, so
    // the binary and Gray registers always move together on the same edge.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
        gray_d = ptr_d ^ (ptr_d >> 1);
    end

    // Local pointer registers, cleared immediately by aclr.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            ptr_q  <= '0;
            gray_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            gray_q <= gray_d;
        end
    end

    assign local_gray = gray_q;
    assign local_addr = ptr_q[W-1:0];

    // ------------------------------------------------------------------
    // Remote pointer resynchronisation.
    // ------------------------------------------------------------------
    logic [W:0] rsync_gray;
    logic [W:0] rsync_bin;

    generate
        if (SYNC_N == 0) begin : g_no_sync
            // Both sides share a clock; no synchroniser is needed.
            assign rsync_gray = remote_gray;
        end else begin : g_sync
            logic [W:0] sync_q [SYNC_N];
            logic [W:0] sync_d [SYNC_N];

            // Shift chain: stage 0 samples the asynchronous Gray input.
            // Each later stage takes the previous stage's value.
            always_comb begin
                sync_d[0] = remote_gray;
                for (int i = 1; i < SYNC_N; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // Synchroniser flops, cleared together with the local pointer.
            always_ff @(posedge clock or posedge aclr) begin
                if (aclr) begin
                    for (int i = 0; i < SYNC_N; i++) begin
                        sync_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < SYNC_N; i++) begin
                        sync_q[i] <= sync_d[i];
                    end
                end
            end

            assign rsync_gray = sync_q[SYNC_N-1];
        end
    endgenerate

    // Gray to binary conversion.
    // Binary bit i is the XOR of all Gray bits at positions i and above.
    // Computing each bit as an independent reduction avoids a bit-serial
    // chain inside one process.
    always_comb begin
        rsync_bin = '0;
        for (int i = 0; i <= W; i++) begin
            rsync_bin[i] = ^(rsync_gray >> i);
        end
    end

    // ------------------------------------------------------------------
    // Word count, modulo 2^(W+1).
    // ------------------------------------------------------------------
    logic [W:0] cnt;

    // The write side counts ahead of the read side in both modes.
    always_comb begin
        cnt = '0;
        if (IS_WRITE) begin
            cnt = ptr_q - rsync_bin;
        end else begin
            cnt = rsync_bin - ptr_q;
        end
    end

`ifdef LPM_FIFO_DC_USEDW_REG_EN
    logic [W:0] cnt_q;
    logic [W:0] cnt_d;

    // Registered count.
    // The flag stage sees a flop output rather than the subtractor output.
    always_comb begin
        cnt_d = cnt;
    end

    // Output count register, cleared by aclr.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign usedw     = cnt_q[W-1:0];
    assign usedw_msb = cnt_q[W];
`else
    assign usedw     = cnt[W-1:0];
    assign usedw_msb = cnt[W];
`endif

    // ------------------------------------------------------------------
    // Simulation-only sanity check.
    // ------------------------------------------------------------------

    // A count above 2^W means the pointers have crossed.
    // This can only happen if the overflow/underflow qualification upstream
    // failed. The outputs still carry the raw modular value in that case.
    a_usedw_overflow : assert property (@(posedge clock) disable iff (aclr) cnt <= FULL_CNT)
        else $error("Error! usedw overflow");

endmodule
